// File: rtl/qif_neuron_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : qif_neuron_scheduler
// Brief    : Round-robin time-multiplexing controller for one shared 8-bit
//            QIF update core. Owns the per-neuron membrane/current registers,
//            walks them one neuron per two-cycle slot (ISSUE, COMMIT) and
//            queues spike events in a 2-entry valid/ready FIFO.
// Options  : QIF_SCHED_REFRAC_EN - builds per-neuron refractory counters that
//            hold a neuron at V_RESET for REFRAC_FRAMES frames after a spike.
// Revision : 1.0 - initial release
// ============================================================================
module qif_neuron_scheduler #(
  parameter int         N_NEURONS     = 4,
  parameter logic [7:0] V_RESET       = 8'd0,
  parameter int         REFRAC_FRAMES = 2,
  localparam int        AW            = $clog2(N_NEURONS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          syn_we,
  input  logic [AW-1:0] syn_addr,
  input  logic [7:0]    syn_in,
  output logic [7:0]    upd_v,
  output logic [7:0]    upd_i,
  input  logic [7:0]    upd_v_next,
  input  logic          upd_spike,
  output logic          spk_valid,
  output logic [AW-1:0] spk_id,
  input  logic          spk_ready,
  output logic          frame_done,
  output logic          spk_ovf,
  input  logic [AW-1:0] mon_addr,
  output logic [7:0]    v_mon
);

  localparam logic [AW-1:0] c_last_idx = AW'(N_NEURONS - 1);

  // Reject unsupported configurations at elaboration time
  if (N_NEURONS < 2 || N_NEURONS > 8 || (N_NEURONS & (N_NEURONS - 1)) != 0 ||
      REFRAC_FRAMES < 1 || REFRAC_FRAMES > 15) begin : g_bad_params
    $error("qif_neuron_scheduler: parameter out of supported range");
  end

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_COMMIT    = 2'd2,
    S_FRAME_END = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_idx;

  logic [7:0]      r_v [N_NEURONS];
  logic [7:0]      r_i [N_NEURONS];

  logic            w_hold;      // current neuron is refractory this slot
  logic            w_commit;
  logic            w_push;      // spike event offered to the FIFO
  logic            w_pop;
  logic            w_full;
  logic            w_push_ok;

  logic [AW-1:0]   r_fifo [2];
  logic            r_rd_ptr;
  logic            r_wr_ptr;
  logic [1:0]      r_count;

  assign w_commit = (r_state == S_COMMIT);

  // State register and neuron index walker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && ena) begin
        r_idx <= '0;
      end else if (w_commit && r_idx != c_last_idx) begin
        r_idx <= r_idx + AW'(1);
      end
    end
  end

  // Next-state decode and the end-of-frame pulse
  always_comb begin
    w_state_next = r_state;
    frame_done   = 1'b0;
    case (r_state)
      S_IDLE:      if (ena) w_state_next = S_ISSUE;
      S_ISSUE:     w_state_next = S_COMMIT;
      S_COMMIT:    w_state_next = (r_idx == c_last_idx) ? S_FRAME_END : S_ISSUE;
      S_FRAME_END: begin
        frame_done   = 1'b1;
        w_state_next = S_IDLE;
      end
      default:     w_state_next = S_IDLE;
    endcase
  end

`ifdef QIF_SCHED_REFRAC_EN
  localparam logic [3:0] c_refrac_load = 4'(REFRAC_FRAMES);

  logic [3:0] r_refrac [N_NEURONS];

  assign w_hold = (r_refrac[r_idx] != 4'd0);

  // Refractory counters: load on spike, count down while holding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) r_refrac[k] <= 4'd0;
    end else if (w_commit) begin
      if (w_hold) begin
        r_refrac[r_idx] <= r_refrac[r_idx] - 4'd1;
      end else if (upd_spike) begin
        r_refrac[r_idx] <= c_refrac_load;
      end
    end
  end
`else
  assign w_hold = 1'b0;
`endif

  assign w_push = w_commit && upd_spike && !w_hold;

  // Operand capture at ISSUE and membrane write-back at COMMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_v <= V_RESET;
      upd_i <= 8'd0;
      for (int k = 0; k < N_NEURONS; k++) r_v[k] <= V_RESET;
    end else begin
      if (r_state == S_ISSUE) begin
        upd_v <= r_v[r_idx];
        upd_i <= r_i[r_idx];
      end
      if (w_commit) begin
        if (w_hold || upd_spike) r_v[r_idx] <= V_RESET;
        else                     r_v[r_idx] <= upd_v_next;
      end
    end
  end

  // Synaptic-current writes are accepted in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) r_i[k] <= 8'd0;
    end else if (syn_we) begin
      r_i[syn_addr] <= syn_in;
    end
  end

  // A push into a full FIFO still fits when the head leaves on the same edge
  assign w_full    = (r_count == 2'd2);
  assign w_pop     = spk_valid && spk_ready;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign spk_valid = (r_count != 2'd0);
  assign spk_id    = r_fifo[r_rd_ptr];

  // Spike FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_count   <= 2'd0;
      spk_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_fifo[r_wr_ptr] <= r_idx;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop};
      if (w_push && !w_push_ok) spk_ovf <= 1'b1;
    end
  end

  // Registered membrane monitor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_mon <= V_RESET;
    else        v_mon <= r_v[mon_addr];
  end

endmodule
`default_nettype wire

// File: doc/qif_neuron_scheduler.md
# qif_neuron_scheduler

Time-multiplexing controller that shares one combinational 8-bit QIF update core among `N_NEURONS` virtual neurons. It owns the per-neuron membrane and synaptic-current registers and walks them round-robin, one neuron per two-cycle slot. It applies the optional refractory hold and queues spike events into a small valid/ready FIFO. It sits between the tile I/O (synapse writes, spike readout) and the shared neuron update core.

## Interface
- `N_NEURONS`, 4: number of virtual neurons; power of two, 2..8; `AW = $clog2(N_NEURONS)`.
- `V_RESET`, 8'd0: membrane value loaded on reset and after a spike.
- `REFRAC_FRAMES`, 2: frames a neuron is held after spiking (only with `QIF_SCHED_REFRAC_EN`); 1..15.
- `clk` in 1: clock. Reset is asynchronous, active-low.
- `rst_n` in 1: asynchronous active-low reset.
- `ena` in 1: frame start enable, sampled only in IDLE.
- `syn_we` in 1: write strobe for the synaptic-current register.
- `syn_addr` in AW: neuron index written by `syn_we`.
- `syn_in` in 8: unsigned current value written.
- `upd_v` out 8: membrane value presented to the update core.
- `upd_i` out 8: current presented to the update core.
- `upd_v_next` in 8: core's combinational next membrane value.
- `upd_spike` in 1: core's combinational threshold-crossed flag.
- `spk_valid` out 1: spike FIFO non-empty.
- `spk_id` out AW: neuron index at the FIFO head.
- `spk_ready` in 1: consumer accepts the head event.
- `frame_done` out 1: one-cycle pulse at the end of each frame.
- `spk_ovf` out 1: sticky flag, set when a spike is dropped on a full FIFO.
- `mon_addr` in AW: neuron selected for monitoring.
- `v_mon` out 8: registered membrane value of `mon_addr`, one cycle of latency.

## Operation
- State registers per neuron: `V[k]` (8b), `I[k]` (8b), `R[k]` (4b refractory count). FIFO: 2 entries of AW bits.
- FSM states and transitions:
  - IDLE → ISSUE when `ena=1`, with `idx=0`.
  - ISSUE → COMMIT, always.
  - COMMIT → ISSUE with `idx+1` when `idx<N_NEURONS-1`; otherwise COMMIT → FRAME_END.
  - FRAME_END → IDLE.
- ISSUE: register `upd_v<=V[idx]` and `upd_i<=I[idx]`.
- COMMIT, normal neuron: `V[idx]<=upd_v_next`.
- COMMIT with `upd_spike=1`: `V[idx]<=V_RESET`, push `idx` to the FIFO, and load `R[idx]<=REFRAC_FRAMES` (refractory build).
- COMMIT with `R[idx]!=0`: ignore `upd_v_next` and `upd_spike`, hold `V[idx]=V_RESET`, decrement `R[idx]`.
- FRAME_END: `frame_done=1` for that single cycle.
- `syn_we=1`: `I[syn_addr]<=syn_in` at the clock edge. It is accepted in every state. If it lands on the same edge as the ISSUE for that neuron, ISSUE samples the old value and the new value is used next frame.
- FIFO push:
  - Push into a full FIFO with no pop in the same cycle → event dropped, `spk_ovf<=1`.
  - Push and pop in the same cycle when full → push accepted.
- FIFO pop on `spk_valid & spk_ready`. Events leave the FIFO in spike order.
- `ena` deasserted mid-frame: the frame still completes. `ena` is only sampled in IDLE.

## Timing
- Reset (async assert, sync release): all `V=V_RESET`, `I=0`, `R=0`; FIFO empty; FSM in IDLE.
- Output reset values: `upd_v=V_RESET`; `upd_i=0`; `spk_valid=0`; `spk_id=0`; `frame_done=0`; `spk_ovf=0`; `v_mon=V_RESET`.
- Frame length: `2*N_NEURONS+1` cycles from leaving IDLE to re-entering IDLE, i.e. 9 cycles for N=4. With `ena` held high, back-to-back frames take `2*N_NEURONS+2` cycles each.
- Spike event visible on `spk_valid` the cycle after its COMMIT edge.
- `rst_n` asserted mid-frame clears all state immediately. No partial commit survives.
- `upd_v_next` is sampled only at the COMMIT edge; its value at any other time is don't-care.

## Configuration
- `QIF_SCHED_REFRAC_EN` defined: `R[k]` counters are built and refractory hold applies as described.
- `QIF_SCHED_REFRAC_EN` undefined: no `R` storage. Every COMMIT samples the core, and a spiking neuron resumes integration from `V_RESET` in the next frame.

## Test plan
- Reset, then idle with `ena=0` for 20 cycles → all outputs at reset values; no `frame_done`.
- Stub core `v_next=v+i`, spike when `v_next>=200`. Write `I[1]=50`, run frames with `ena=1` → `V[1]` reads 50, 100, 150 on `v_mon`. In frame 4 a spike occurs: `spk_id=1`, `V[1]=0`. `frame_done` pulses every 10 cycles.
- With `QIF_SCHED_REFRAC_EN`, same stimulus → `V[1]` held at 0 for 2 frames after the spike, then reads 50. Without the macro → `V[1]` reads 50 in the frame right after the spike.
- All four neurons spike in one frame with `spk_ready=0` → FIFO holds ids 0 and 1; `spk_ovf=1`. Raising `spk_ready` pops 0, then 1, then `spk_valid=0`.
- `syn_we` to neuron 2 on its ISSUE edge with `syn_in=9` (old value 5) → this frame uses 5, the next frame uses 9.
- `rst_n` pulsed low during neuron 2's COMMIT → everything returns to reset values; the next frame starts from `V_RESET` for all neurons.
